// File: rtl/cam_match_reporter_if.sv
`default_nettype none
// ============================================================================
// Module      : cam_match_reporter_if
// Description : Control, match-vector and index-stream bundle between the
//               CAM match reporter and the logic around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface cam_match_reporter_if #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 5
);
    logic                 start_i;
    logic                 flush_i;
    logic [N_ENTRIES-1:0] match_vec_i;
    logic                 out_ready_i;
    logic                 out_valid_o;
    logic [IDX_W-1:0]     out_addr_o;
    logic                 out_last_o;
    logic [CNT_W-1:0]     hit_count_o;
    logic                 no_match_o;
    logic                 busy_o;
    logic                 done_o;

    // Side that issues reports and consumes the index stream
    modport master (
        output start_i, flush_i, match_vec_i, out_ready_i,
        input  out_valid_o, out_addr_o, out_last_o, hit_count_o,
               no_match_o, busy_o, done_o
    );

    // The reporter itself
    modport slave (
        input  start_i, flush_i, match_vec_i, out_ready_i,
        output out_valid_o, out_addr_o, out_last_o, hit_count_o,
               no_match_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/cam_match_reporter.sv
`default_nettype none
// ============================================================================
// Module      : cam_match_reporter
// Description : Captures a CAM match vector on start and streams every hit
//               index (lowest first) over valid/ready, with hit count,
//               no-match flag, busy level and a completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_match_reporter #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cam_match_reporter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N_ENTRIES-1:0] c_ONE = N_ENTRIES'(1);

    logic [1:0]           state_q,     state_d;
    logic [N_ENTRIES-1:0] pending_q,   pending_d;
    logic [CNT_W-1:0]     hit_count_q, hit_count_d;
    logic                 no_match_q,  no_match_d;

    logic [IDX_W-1:0]     w_low_idx;
    logic [N_ENTRIES-1:0] w_low_mask;
    logic                 w_single;
    logic [CNT_W-1:0]     w_popcnt;
    logic                 w_vec_zero;

    // Index of the lowest pending hit (highest-to-lowest scan, last write wins)
    always_comb begin
        w_low_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit; clearing the lowest
    // bit leaving zero means exactly one hit remains.
    assign w_low_mask = pending_q & (~pending_q + c_ONE);
    assign w_single   = (pending_q != '0) && ((pending_q & (pending_q - c_ONE)) == '0);
    assign w_vec_zero = (bus.match_vec_i == '0);

    // Population count of the incoming match vector
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_popcnt = w_popcnt + CNT_W'(bus.match_vec_i[i]);
        end
    end

    // Next-state logic; flush overrides start and any in-flight accept
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hit_count_d = hit_count_q;
        no_match_d  = no_match_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    pending_d   = bus.match_vec_i;
                    hit_count_d = w_popcnt;
                    no_match_d  = w_vec_zero;
                    state_d     = w_vec_zero ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.out_ready_i) begin
                    pending_d = pending_q & ~w_low_mask;
                    if (w_single) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
        if (bus.flush_i) begin
            state_d     = S_IDLE;
            pending_d   = '0;
            hit_count_d = hit_count_q;
            no_match_d  = no_match_q;
        end
    end

    // State and report registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            hit_count_q <= '0;
            no_match_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
            no_match_q  <= no_match_d;
        end
    end

    // Outputs come from registered state only; pending is zero outside EMIT
    assign bus.out_valid_o = (state_q == S_EMIT);
    assign bus.out_addr_o  = w_low_idx;
    assign bus.out_last_o  = (state_q == S_EMIT) && w_single;
    assign bus.hit_count_o = hit_count_q;
    assign bus.no_match_o  = no_match_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cam_match_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_match_reporter
// Description : Self-checking bench for cam_match_reporter: directed report
//               scenarios plus randomized start/flush/ready/reset traffic,
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_match_reporter;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cam_match_reporter_if #(.N_ENTRIES(N), .IDX_W(4), .CNT_W(5)) bus ();

    cam_match_reporter #(.N_ENTRIES(N), .IDX_W(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending hits as an ascending index queue
    int mq[$];
    bit m_done = 1'b0;
    int m_hit  = 0;
    bit m_nom  = 1'b0;

    // Observation logs filled by the compare process
    bit chk_en    = 1'b0;
    int acc_log[$];
    int last_log[$];
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int valid_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string nm, input int act[$], input int exp[$]);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %p expected %p", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        last_log.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 100; k++) begin
            step();
            if (done_cnt > 0) break;
        end
        if (done_cnt == 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_start(input logic [N-1:0] v);
        bus.match_vec_i = v;
        bus.start_i     = 1'b1;
        step();
        bus.start_i     = 1'b0;
    endtask

    // Model update at each rising edge from the inputs presented that cycle
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_done = 1'b0;
                m_hit  = 0;
                m_nom  = 1'b0;
            end else if (bus.flush_i) begin
                mq.delete();
                m_done = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (mq.size() > 0) begin
                if (bus.out_ready_i) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_done = 1'b1;
                end
            end else if (bus.start_i) begin
                for (int i = 0; i < N; i++) if (bus.match_vec_i[i]) mq.push_back(i);
                m_hit  = $countones(bus.match_vec_i);
                m_nom  = (bus.match_vec_i == '0);
                m_done = (bus.match_vec_i == '0);
            end
        end
    end

    // Compare process on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("valid", int'(bus.out_valid_o), int'(mq.size() > 0));
                if (mq.size() > 0) chk("addr", int'(bus.out_addr_o), mq[0]);
                chk("last", int'(bus.out_last_o), int'(mq.size() == 1));
                chk("busy", int'(bus.busy_o), int'(mq.size() > 0 || m_done));
                chk("done", int'(bus.done_o), int'(m_done));
                chk("hit_count", int'(bus.hit_count_o), m_hit);
                chk("no_match", int'(bus.no_match_o), int'(m_nom));
                if (bus.out_valid_o && bus.out_ready_i) begin
                    acc_log.push_back(int'(bus.out_addr_o));
                    if (bus.out_last_o) last_log.push_back(int'(bus.out_addr_o));
                end
                if (bus.done_o)      done_cnt++;
                if (bus.busy_o)      busy_cnt++;
                if (bus.out_valid_o) valid_cnt++;
            end
        end
    end

    initial begin
        int exp_all[$];
        bus.start_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.match_vec_i = '0;
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", int'(bus.out_valid_o), 0);
        chk("rst_addr",  int'(bus.out_addr_o), 0);
        chk("rst_busy",  int'(bus.busy_o), 0);
        chk("rst_hit",   int'(bus.hit_count_o), 0);
        step();

        // Zero-hit report: done pulse in the cycle after start
        clear_logs();
        pulse_start(16'h0000);
        chk("t1_done_latency", int'(bus.done_o), 1);
        wait_done("t1");
        chk("t1_valid_cnt", valid_cnt, 0);
        chk("t1_done_cnt",  done_cnt, 1);
        chk("t1_no_match",  int'(bus.no_match_o), 1);
        chk("t1_hit",       int'(bus.hit_count_o), 0);
        step();

        // Sparse vector, ready held high
        clear_logs();
        bus.out_ready_i = 1'b1;
        pulse_start(16'h8421);
        chk("t2_first_valid", int'(bus.out_valid_o), 1);
        chk("t2_first_addr",  int'(bus.out_addr_o), 0);
        wait_done("t2");
        chk_q("t2_indices", acc_log, '{0, 5, 10, 15});
        chk_q("t2_last",    last_log, '{15});
        chk("t2_hit", int'(bus.hit_count_o), 4);
        chk("t2_busy_cycles", busy_cnt, 5);
        step();

        // Back-pressure: index 1 held while ready is low
        clear_logs();
        bus.out_ready_i = 1'b0;
        pulse_start(16'h0006);
        repeat (3) step();
        chk("t3_hold_valid", int'(bus.out_valid_o), 1);
        chk("t3_hold_addr",  int'(bus.out_addr_o), 1);
        chk("t3_hold_last",  int'(bus.out_last_o), 0);
        bus.out_ready_i = 1'b1;
        wait_done("t3");
        chk_q("t3_indices", acc_log, '{1, 2});
        chk_q("t3_last",    last_log, '{2});
        step();

        // All entries hit
        clear_logs();
        pulse_start(16'hFFFF);
        wait_done("t4");
        for (int i = 0; i < N; i++) exp_all.push_back(i);
        chk_q("t4_indices", acc_log, exp_all);
        chk_q("t4_last",    last_log, '{15});
        chk("t4_hit", int'(bus.hit_count_o), 16);
        chk("t4_busy_cycles", busy_cnt, 17);
        step();

        // Start during EMIT ignored
        clear_logs();
        bus.out_ready_i = 1'b0;
        pulse_start(16'h00F0);
        bus.match_vec_i = 16'hFFFF;
        bus.start_i     = 1'b1;
        step();
        bus.start_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        wait_done("t5");
        chk_q("t5_indices", acc_log, '{4, 5, 6, 7});
        chk("t5_hit", int'(bus.hit_count_o), 4);
        step();

        // Start held through EMIT and DONE cycles is ignored
        clear_logs();
        bus.match_vec_i = 16'h0001;
        bus.start_i     = 1'b1;
        step();
        bus.match_vec_i = 16'h0003;
        step();
        step();
        bus.start_i = 1'b0;
        chk("t5b_busy", int'(bus.busy_o), 0);
        chk("t5b_hit",  int'(bus.hit_count_o), 1);
        chk_q("t5b_indices", acc_log, '{0});
        step();

        // Flush after two of four indices
        clear_logs();
        pulse_start(16'h0F00);
        step();
        step();
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b1;
        step();
        bus.flush_i     = 1'b0;
        chk("t6_valid", int'(bus.out_valid_o), 0);
        chk("t6_busy",  int'(bus.busy_o), 0);
        chk("t6_hit_kept", int'(bus.hit_count_o), 4);
        step();
        chk("t6_done_cnt", done_cnt, 0);
        chk_q("t6_indices", acc_log, '{8, 9});

        // Reset after two of four indices
        clear_logs();
        bus.out_ready_i = 1'b1;
        pulse_start(16'h00F0);
        step();
        step();
        bus.out_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6r_valid", int'(bus.out_valid_o), 0);
        chk("t6r_hit",   int'(bus.hit_count_o), 0);
        step();
        chk("t6r_done_cnt", done_cnt, 0);
        chk_q("t6r_indices", acc_log, '{4, 5});

        // New report after reset runs normally
        clear_logs();
        bus.out_ready_i = 1'b1;
        pulse_start(16'h0003);
        wait_done("t6n");
        chk_q("t6n_indices", acc_log, '{0, 1});
        step();

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            bus.start_i     = ($urandom_range(0, 3) == 0);
            bus.match_vec_i = ($urandom_range(0, 7) == 0) ? 16'h0000 : N'($urandom);
            if ($urandom_range(0, 3) == 0) bus.match_vec_i = bus.match_vec_i & N'($urandom);
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            bus.flush_i     = ($urandom_range(0, 24) == 0);
            rst             = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
